// File: rtl/psum_drain_deskew_pkg.sv
// Shared accelerator definitions for the psum drain path.
//  - default array geometry (columns, accumulator width)
//  - col_lsb(): low bit index of column c inside a packed row vector
package psum_drain_deskew_pkg;

   localparam int ARRAY_SIZE_DEF = 4;
   localparam int ACC_WIDTH_DEF  = 32;

   function automatic int col_lsb(input int col, input int acc_w);
      return col * acc_w;
   endfunction

endpackage

// File: rtl/psum_drain_deskew_if.sv
// Aligned-row stream from the drain block to the writeback path.
//  data  : packed row, column c at [c*ACC_WIDTH +: ACC_WIDTH]
//  valid : data holds a row
//  ready : consumer accepts when valid && ready
//  last  : row is the final row of its tile
interface psum_drain_deskew_if #(
   parameter int W = 128
);
   logic [W-1:0] data;
   logic         valid;
   logic         ready;
   logic         last;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/psum_drain_deskew_fifo.sv
// sync_fifo_sa: show-ahead synchronous FIFO with occupancy count.
//  clk, rst_n : clock, async active-low reset
//  clr        : synchronous clear of pointers and count
//  wr_en      : write request; accepted if not full, or full with a read on the same edge
//  wr_data    : entry to write
//  rd_en      : pop head (ignored when empty)
//  rd_data    : head entry, forced to zero while empty
//  count      : occupancy, one bit wider than the pointers
//  wr_drop    : write request rejected because the FIFO is full
module sync_fifo_sa #(
   parameter  int W     = 129,
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          wr_en,
   input  logic [W-1:0]  wr_data,
   input  logic          rd_en,
   output logic [W-1:0]  rd_data,
   output logic [AW:0]   count,
   output logic          wr_drop
);
   localparam logic [AW:0]   CNT_ONE = 1;
   localparam logic [AW-1:0] PTR_ONE = 1;
   localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          empty;
   logic          full;
   logic          do_rd;
   logic          do_wr;

   assign empty   = (count == '0);
   assign full    = (count == CNT_MAX);
   assign do_rd   = rd_en && !empty;
   // a same-edge read frees the slot, so a write into a full FIFO still lands
   assign do_wr   = wr_en && (!full || do_rd);
   assign wr_drop = wr_en && full && !do_rd;
   assign rd_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
         case ({do_wr, do_rd})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/psum_drain_deskew.sv
// psum_drain_deskew: collects the bottom-row psums of the systolic array,
// removes the per-column skew, and buffers each aligned output row.
//  clk, rst_n : clock, async active-low reset
//  flush      : synchronous clear of all state
//  array_en   : array pipeline enable; deskew advances only when high
//  psum_in    : bottom-row psums, column c at [c*ACC_WIDTH +: ACC_WIDTH]
//  in_valid   : column 0 of a new output row is on psum_in
//  cfg_rows   : rows per tile, sampled at the start of a tile (0 acts as 1)
//  out_if     : aligned-row stream (data/valid/ready/last)
//  stall_req  : array must hold array_en low while set
//  ovf_err    : sticky, an aligned row was dropped on a full FIFO
module psum_drain_deskew
   import psum_drain_deskew_pkg::*;
#(
   parameter int ARRAY_SIZE = ARRAY_SIZE_DEF,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int FIFO_DEPTH = 8,
   parameter int ROW_CNT_W  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            flush,
   input  logic                            array_en,
   input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] psum_in,
   input  logic                            in_valid,
   input  logic [ROW_CNT_W-1:0]            cfg_rows,
   psum_drain_deskew_if.master             out_if,
   output logic                            stall_req,
   output logic                            ovf_err
);
   localparam int N  = ARRAY_SIZE;
   localparam int RW = N * ACC_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [ROW_CNT_W-1:0] ROW_ONE = 1;

   logic [RW-1:0]        aligned;
   logic [N-2:0]         vpipe;
   logic                 aligned_valid;
   logic                 wr_en;
   logic                 wr_drop;
   logic [RW:0]          head;
   logic [AW:0]          count;
   logic [AW:0]          free_slots;
   logic [ROW_CNT_W-1:0] row_cnt;
   logic [ROW_CNT_W-1:0] rows_q;
   logic [ROW_CNT_W-1:0] eff_rows;
   logic                 is_last;

   // Column c lags column 0 by c enabled cycles, so it gets N-1-c stages.
   for (genvar c = 0; c < N-1; c++) begin : g_dl
      localparam int D = N - 1 - c;
      logic [ACC_WIDTH-1:0] dl [D];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < D; i++) dl[i] <= '0;
         end else if (flush) begin
            for (int i = 0; i < D; i++) dl[i] <= '0;
         end else if (array_en) begin
            dl[0] <= psum_in[col_lsb(c, ACC_WIDTH) +: ACC_WIDTH];
            for (int i = 1; i < D; i++) dl[i] <= dl[i-1];
         end
      end

      assign aligned[col_lsb(c, ACC_WIDTH) +: ACC_WIDTH] = dl[D-1];
   end

   assign aligned[col_lsb(N-1, ACC_WIDTH) +: ACC_WIDTH] =
      psum_in[col_lsb(N-1, ACC_WIDTH) +: ACC_WIDTH];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vpipe <= '0;
      end else if (flush) begin
         vpipe <= '0;
      end else if (array_en) begin
         vpipe[0] <= in_valid;
         for (int i = 1; i < N-1; i++) vpipe[i] <= vpipe[i-1];
      end
   end

   assign aligned_valid = vpipe[N-2];
   assign wr_en         = array_en && aligned_valid;

   // Tile length is latched on the first row so a cfg change mid-tile
   // cannot move the last flag.
   assign eff_rows = (row_cnt == '0) ? ((cfg_rows == '0) ? ROW_ONE : cfg_rows) : rows_q;
   assign is_last  = (row_cnt == eff_rows - ROW_ONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt <= '0;
         rows_q  <= ROW_ONE;
      end else if (flush) begin
         row_cnt <= '0;
         rows_q  <= ROW_ONE;
      end else if (wr_en) begin
         if (row_cnt == '0) rows_q <= eff_rows;
         row_cnt <= is_last ? '0 : row_cnt + ROW_ONE;
      end
   end

   sync_fifo_sa #(
      .W     (RW + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .wr_en   (wr_en),
      .wr_data ({is_last, aligned}),
      .rd_en   (out_if.ready),
      .rd_data (head),
      .count   (count),
      .wr_drop (wr_drop)
   );

   assign out_if.data  = head[RW-1:0];
   assign out_if.last  = head[RW];
   assign out_if.valid = (count != '0);

   // Leaves room for the up to N-1 rows still inside the deskew lines.
   assign free_slots = (AW+1)'(FIFO_DEPTH) - count;
   assign stall_req  = (free_slots <= (AW+1)'(N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ovf_err <= 1'b0;
      else if (flush)   ovf_err <= 1'b0;
      else if (wr_drop) ovf_err <= 1'b1;
   end

endmodule
